// File: rtl/clkdiv_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// clkdiv_ctrl : programmable 50%-duty integer clock divider with control FSM
// Rev 1.0
// ============================================================================
module clkdiv_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 7
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_tick,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_def_div = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_two     = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             clkp_q, clkp_d;
    logic             clkn_q, clkn_d;
    logic             cfg_err_q, cfg_err_d;

    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_half_m1;
    logic             w_wrap;
    logic             w_xfer;
    logic             w_accept;

    always_comb begin
        w_last    = cur_div_q - c_one;
        w_half_m1 = (cur_div_q >> 1) - c_one;
        w_wrap    = (cnt_q == w_last);
        w_xfer    = cfg_valid & ~pend_q;
        w_accept  = w_xfer & (cfg_div >= c_two);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clkp_d     = clkp_q;
        cur_div_d  = cur_div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = w_xfer & (cfg_div < c_two);
        clkn_d     = clkp_q;

        case (state_q)
            ST_OFF: begin
                cnt_d  = '0;
                clkp_d = 1'b0;
                if (w_accept) begin
                    cur_div_d = cfg_div;
                end
                // A transfer on the start edge already uses the new divisor,
                // because cur_div feeds the compares only from the next edge on.
                if (en) begin
                    state_d = ST_RUN;
                    clkp_d  = 1'b1;
                end
            end
            default: begin
                state_d = en ? ST_RUN : ST_STOP;
                if (w_wrap) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        cur_div_d = pend_div_q;
                        pend_d    = 1'b0;
                    end
                    if (state_q == ST_STOP && !en) begin
                        // No further period: a value offered now takes effect directly.
                        state_d = ST_OFF;
                        clkp_d  = 1'b0;
                        if (w_accept) begin
                            cur_div_d = cfg_div;
                        end
                    end else begin
                        clkp_d = 1'b1;
                        if (w_accept) begin
                            pend_d     = 1'b1;
                            pend_div_d = cfg_div;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + c_one;
                    if (cnt_q == w_half_m1) begin
                        clkp_d = 1'b0;
                    end
                    if (w_accept) begin
                        pend_d     = 1'b1;
                        pend_div_d = cfg_div;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            clkp_q     <= 1'b0;
            cur_div_q  <= c_def_div;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clkp_q     <= clkp_d;
            cur_div_q  <= cur_div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Half-cycle extension of the high phase for odd divisors.
    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
            clkn_q <= 1'b0;
        end else begin
            clkn_q <= clkn_d;
        end
    end

    always_comb begin
        running     = (state_q != ST_OFF);
        period_tick = running && (cnt_q == '0);
        cfg_ready   = ~pend_q;
        cfg_err     = cfg_err_q;
        cur_div     = cur_div_q;
        clk_out     = clkp_q | (cur_div_q[0] & clkn_q);
    end

endmodule
`default_nettype wire
